scancode_display_ctrl: RTL

Parametrised successor to the keyboard LED controller. It sits between the PS/2 receiver (`scancode`/`scan_ready`) and the board LEDs. A prefix state machine decodes `E0` (extended) and `F0` (break) prefixes into complete key events. The block keeps a circular history of the last `DEPTH` make codes and a make-event counter, and drives `led` from one of four selectable display modes.

---
 rtl/scancode_pkg.sv | 21 ++
 rtl/scancode_history.sv | 36 +++
 rtl/scancode_display_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/scancode_pkg.sv
// Shared constants and enums for the PS/2 scancode display controller.
package scancode_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_t;

  typedef enum logic [1:0] {
    MODE_RAW   = 2'd0,
    MODE_MAKE  = 2'd1,
    MODE_HIST  = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

endpackage

// File: rtl/scancode_history.sv
// Circular buffer of the most recent make codes; read index 0 is the newest entry.
module scancode_history #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_sel,
  output logic [WIDTH-1:0]         o_rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    w_rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
    end else if (i_push) begin
      r_mem[r_wptr] <= i_push_data;
      r_wptr        <= r_wptr + AW'(1);
    end
  end

  // DEPTH is a power of two, so the subtraction wraps naturally.
  assign w_rd_idx  = r_wptr - AW'(1) - i_rd_sel;
  assign o_rd_data = r_mem[w_rd_idx];

endmodule

// File: rtl/scancode_display_ctrl.sv
// PS/2 prefix decoder with make history, make counter and a selectable LED display.
//   state   | meaning
//   IDLE    | no prefix pending
//   EXT     | E0 seen
//   BRK     | F0 seen
//   EXT_BRK | E0 and F0 both seen
module scancode_display_ctrl
  import scancode_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LED_W = 8,
  parameter logic [LED_W-1:0] RST_LED = LED_W'(8'b0111_1110)
) (
  input  logic                     CLK50MHZ,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         scancode,
  input  logic                     scan_ready,
  input  logic [1:0]               mode,
  input  logic [$clog2(DEPTH)-1:0] sel,
  output logic [LED_W-1:0]         led,
  output logic                     key_valid,
  output logic [WIDTH-1:0]         key_code,
  output logic                     key_ext,
  output logic                     key_break,
  output logic [LED_W-1:0]         make_count
);

  localparam logic [WIDTH-1:0] W_EXT = WIDTH'(SC_EXT);
  localparam logic [WIDTH-1:0] W_BRK = WIDTH'(SC_BRK);

  prefix_state_t    r_state;
  prefix_state_t    w_state_next;
  logic             w_event;
  logic             w_ev_ext;
  logic             w_ev_brk;
  logic             w_push;

  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] r_make;
  logic [LED_W-1:0] r_count;
  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_led_next;
  logic             r_key_valid;
  logic [WIDTH-1:0] r_key_code;
  logic             r_key_ext;
  logic             r_key_break;
  logic [WIDTH-1:0] w_hist_data;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (scan_ready) begin
      if (scancode == W_EXT) begin
        case (r_state)
          IDLE:    w_state_next = EXT;
          BRK:     w_state_next = EXT_BRK;
          default: w_state_next = r_state;
        endcase
      end else if (scancode == W_BRK) begin
        case (r_state)
          IDLE:    w_state_next = BRK;
          EXT:     w_state_next = EXT_BRK;
          default: w_state_next = r_state;
        endcase
      end else begin
        w_state_next = IDLE;
      end
    end
  end

  always_comb begin
    w_event  = scan_ready && (scancode != W_EXT) && (scancode != W_BRK);
    w_ev_ext = (r_state == EXT) || (r_state == EXT_BRK);
    w_ev_brk = (r_state == BRK) || (r_state == EXT_BRK);
    w_push   = w_event && !w_ev_brk;
  end

  scancode_history #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_history (
    .clk         (CLK50MHZ),
    .rst         (RST),
    .i_push      (w_push),
    .i_push_data (scancode),
    .i_rd_sel    (sel),
    .o_rd_data   (w_hist_data)
  );

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_raw       <= '0;
      r_make      <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
    end else begin
      r_key_valid <= w_event;
      if (scan_ready) begin
        r_raw <= scancode;
      end
      if (w_event) begin
        r_key_code  <= scancode;
        r_key_ext   <= w_ev_ext;
        r_key_break <= w_ev_brk;
      end
      if (w_push) begin
        r_make  <= scancode;
        r_count <= r_count + LED_W'(1);
      end
    end
  end

  // The LED register samples the already-updated state, adding one edge of latency.
  always_comb begin
    w_led_next = '0;
    case (mode_t'(mode))
      MODE_RAW:   w_led_next = LED_W'(r_raw);
      MODE_MAKE:  w_led_next = LED_W'(r_make);
      MODE_HIST:  w_led_next = LED_W'(w_hist_data);
      MODE_COUNT: w_led_next = r_count;
      default:    w_led_next = '0;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_led <= RST_LED;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign led        = r_led;
  assign key_valid  = r_key_valid;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_break  = r_key_break;
  assign make_count = r_count;

endmodule
